// File: rtl/fetch_queue_if.sv
// Bundle of fetch-front-end signals: instruction-memory request/response,
// decode-side instruction stream, redirect input and occupancy debug output.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                             fetch_en;
    logic                             redirect_valid;
    logic [XLEN-1:0]                  redirect_pc;
    logic                             imem_req_valid;
    logic                             imem_req_ready;
    logic [XLEN-1:0]                  imem_req_addr;
    logic                             imem_rsp_valid;
    logic [XLEN-1:0]                  imem_rsp_data;
    logic                             instr_valid;
    logic                             instr_ready;
    logic [XLEN-1:0]                  instr_data;
    logic [XLEN-1:0]                  instr_pc;
    logic [$clog2(DEPTH+1)-1:0]       occupancy;

    // master is the fetch queue itself; slave is the surrounding core/memory
    modport master (
        input  fetch_en, redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        output imem_req_valid, imem_req_addr,
        output instr_valid, instr_data, instr_pc, occupancy
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        input  imem_req_valid, imem_req_addr,
        input  instr_valid, instr_data, instr_pc, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited requests
// and buffers PC-tagged responses in a circular queue, flushing on redirect.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    // in-flight count can reach DEPTH stale plus DEPTH fresh after a redirect
    localparam int OW = $clog2(DEPTH) + 2;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [OW-1:0]   outstanding_reg;
    logic [OW-1:0]   outstanding_next;
    logic [OW-1:0]   drop_cnt_reg;
    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   tag_rd_reg;
    logic [AW-1:0]   tag_wr_reg;

    logic [XLEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] tag_mem  [DEPTH];

    logic [OW:0]      credit;
    logic             accept;
    logic             rsp_keep;
    logic             pop;
    logic             push_tag;
    logic [DEPTH-1:0] wr_sel;
    logic [DEPTH-1:0] tag_sel;

    // slots already promised: buffered entries plus responses that will be kept
    assign credit = (OW+1)'(count_reg) + (OW+1)'(outstanding_reg) - (OW+1)'(drop_cnt_reg);

    assign bus.imem_req_valid = !rst && bus.fetch_en && (credit < (OW+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc_reg;

    assign accept   = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep = bus.imem_rsp_valid && (drop_cnt_reg == '0) && !bus.redirect_valid;
    assign pop      = (count_reg != '0) && bus.instr_ready && !bus.redirect_valid;
    // requests accepted during a redirect carry a stale PC and are dropped, so no tag
    assign push_tag = accept && !bus.redirect_valid;

    assign outstanding_next = outstanding_reg + OW'(accept) - OW'(bus.imem_rsp_valid);

    assign bus.instr_valid = (count_reg != '0);
    assign bus.instr_data  = data_mem[rd_ptr_reg];
    assign bus.instr_pc    = pc_mem[rd_ptr_reg];
    assign bus.occupancy   = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign wr_sel[gi]  = rsp_keep && (wr_ptr_reg == AW'(gi));
            assign tag_sel[gi] = push_tag && (tag_wr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            tag_rd_reg      <= '0;
            tag_wr_reg      <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (bus.redirect_valid) begin
                fetch_pc_reg <= bus.redirect_pc;
                drop_cnt_reg <= outstanding_next;
                count_reg    <= '0;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                tag_rd_reg   <= '0;
                tag_wr_reg   <= '0;
            end else begin
                if (accept)
                    fetch_pc_reg <= fetch_pc_reg + PC_STEP;
                if (bus.imem_rsp_valid && (drop_cnt_reg != '0))
                    drop_cnt_reg <= drop_cnt_reg - OW'(1);
                if (rsp_keep) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    tag_rd_reg <= tag_rd_reg + AW'(1);
                end
                if (push_tag)
                    tag_wr_reg <= tag_wr_reg + AW'(1);
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                count_reg <= count_reg + CW'(rsp_keep) - CW'(pop);
            end
        end
    end

    // queue storage is cleared on reset so the head reads zero while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    data_mem[i] <= bus.imem_rsp_data;
                    pc_mem[i]   <= tag_mem[tag_rd_reg];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (tag_sel[i])
                tag_mem[i] <= fetch_pc_reg;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order, fixed-latency memory model
// returning the inverted address as the instruction word.
module tb_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(32'h4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int cyc    = 0;

    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] got_pc  [$];
    logic [31:0] got_data[$];
    logic [31:0] acc_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock: sample handshakes at negedge, advance, then drive memory response
    task automatic step();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        if (acc) acc_log.push_back(a);
        if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
            got_pc.push_back(bus.instr_pc);
            got_data.push_back(bus.instr_data);
            $display("instr pc=%h data=%h", bus.instr_pc, bus.instr_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc && !rst) begin
            mq_addr.push_back(a);
            mq_due.push_back(cyc + lat - 1);
        end
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = ~mq_addr[0];
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mq_addr.delete();
        mq_due.delete();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        steps(2);
        rst = 1'b0;
        got_pc.delete();
        got_data.delete();
        acc_log.delete();
    endtask

    initial begin
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b1;

        // reset values, observed before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("rst_req_addr",  bus.imem_req_addr,       32'h0);
        check("rst_instr_valid", 32'(bus.instr_valid),  32'h0);
        check("rst_occupancy", 32'(bus.occupancy),      32'h0);
        check("rst_instr_pc",  bus.instr_pc,            32'h0);

        // sequential fetch, 1-cycle memory
        lat = 1;
        do_reset();
        step();
        check("fill_valid_e1", 32'(bus.instr_valid), 32'h0);
        step();
        check("fill_valid_e2", 32'(bus.instr_valid), 32'h1);
        check("fill_pc_e2",    bus.instr_pc,          32'h0);
        check("fill_data_e2",  bus.instr_data,        32'hFFFF_FFFF);
        steps(6);
        check("seq_pc0", got_pc[0], 32'h0);
        check("seq_pc1", got_pc[1], 32'h4);
        check("seq_pc2", got_pc[2], 32'h8);
        check("seq_pc3", got_pc[3], 32'hC);
        check("seq_data3", got_data[3], 32'hFFFF_FFF3);

        // backpressure: queue fills, credit stops requests
        bus.instr_ready = 1'b0;
        do_reset();
        steps(10);
        check("bp_accepts",   32'(acc_log.size()),      32'd4);
        check("bp_occupancy", 32'(bus.occupancy),       32'd4);
        check("bp_req_valid", 32'(bus.imem_req_valid),  32'h0);
        check("bp_req_addr",  bus.imem_req_addr,        32'h10);
        bus.instr_ready = 1'b1;
        steps(8);
        check("bp_pc0", got_pc[0], 32'h0);
        check("bp_pc1", got_pc[1], 32'h4);
        check("bp_pc2", got_pc[2], 32'h8);
        check("bp_pc3", got_pc[3], 32'hC);
        check("bp_pc4", got_pc[4], 32'h10);
        check("bp_resume_addr", acc_log[4], 32'h10);

        // redirect with two stale responses in flight, 3-cycle memory
        lat = 3;
        do_reset();
        steps(5);
        check("rd3_occupancy", 32'(bus.occupancy), 32'd1);
        check("rd3_head_pc",   bus.instr_pc,       32'h4);
        got_pc.delete();
        got_data.delete();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        check("rd3_valid_after", 32'(bus.instr_valid), 32'h0);
        check("rd3_occ_after",   32'(bus.occupancy),   32'h0);
        step();
        check("rd3_stale_dropped", 32'(bus.instr_valid), 32'h0);
        steps(6);
        check("rd3_pc0",   got_pc[0],   32'h100);
        check("rd3_pc1",   got_pc[1],   32'h104);
        check("rd3_data0", got_data[0], 32'hFFFF_FEFF);

        // redirect coinciding with a response and a request accept
        lat = 1;
        do_reset();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        check("rdx_accept_old_pc", acc_log[1], 32'h4);
        check("rdx_valid_e2", 32'(bus.instr_valid), 32'h0);
        step();
        check("rdx_valid_e3", 32'(bus.instr_valid), 32'h0);
        step();
        check("rdx_valid_e4", 32'(bus.instr_valid), 32'h1);
        check("rdx_pc_e4",    bus.instr_pc,          32'h200);
        check("rdx_no_stale", 32'(got_pc.size()),    32'd0);

        // PC wrap through redirect target near the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        step();
        bus.redirect_valid = 1'b0;
        got_pc.delete();
        got_data.delete();
        steps(8);
        check("wrap_pc0",   got_pc[0],   32'hFFFF_FFF8);
        check("wrap_pc1",   got_pc[1],   32'hFFFF_FFFC);
        check("wrap_pc2",   got_pc[2],   32'h0000_0000);
        check("wrap_data2", got_data[2], 32'hFFFF_FFFF);

        // asynchronous reset between clock edges with three entries buffered
        bus.instr_ready = 1'b0;
        do_reset();
        steps(4);
        check("ar_occ_before", 32'(bus.occupancy), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("ar_instr_valid", 32'(bus.instr_valid),    32'h0);
        check("ar_occupancy",   32'(bus.occupancy),      32'h0);
        check("ar_req_valid",   32'(bus.imem_req_valid), 32'h0);
        bus.instr_ready = 1'b1;
        do_reset();
        steps(3);
        check("ar_restart_addr", acc_log[0], 32'h0);
        check("ar_restart_pc",   got_pc[0],  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the next-generation core. Replaces the bare PC register and combinational instruction-memory hookup.
- Owns the fetch PC and issues in-order requests to a latency-tolerant instruction memory.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry circular queue.
- On a branch/jump redirect, flushes the queue and discards stale in-flight responses.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- DEPTH, 4, queue entries; power of two, >=2.
- RESET_PC, 0, fetch PC after reset.
- PC_STEP, 4, PC increment per sequential fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  when 0, no new requests are issued; queue and in-flight traffic still complete.
- redirect_valid  in  1  one-cycle pulse from PC-select logic: branch taken, jal or jalr.
- redirect_pc  in  XLEN  target PC; valid with redirect_valid.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  request address; equals fetch_pc.
- imem_rsp_valid  in  1  response word valid; responses return in request order, latency >=1 cycle.
- imem_rsp_data  in  XLEN  response instruction word.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decode consumes the head this cycle.
- instr_data  out  XLEN  head instruction.
- instr_pc  out  XLEN  PC of head instruction.
- occupancy  out  clog2(DEPTH+1)  current queue entry count (debug/perf).

Behaviour:
- Reset (async, while rst=1):
  - fetch_pc=RESET_PC; rd_ptr=wr_ptr=0; count=0; outstanding=0; drop_cnt=0.
  - All outputs 0 except imem_req_addr=RESET_PC. imem_req_valid is forced 0 while rst=1.
  - Assertion of rst mid-transfer abandons everything; responses arriving after rst deasserts are not expected by the bench.
- Credit rule:
  - imem_req_valid = fetch_en && (count + outstanding - drop_cnt) < DEPTH.
  - Combinational from registers only; never depends on imem_req_ready.
  - This guarantees every non-dropped response has a free slot; the queue never overflows.
- Request accept (imem_req_valid && imem_req_ready):
  - outstanding += 1.
  - fetch_pc += PC_STEP, modulo 2^XLEN (wraps silently).
- Response arrival (imem_rsp_valid):
  - outstanding -= 1.
  - If drop_cnt>0: drop_cnt -= 1 and the word is discarded.
  - Otherwise: write {data, pc} at wr_ptr; wr_ptr += 1 (mod DEPTH); count += 1.
  - Entry PC comes from a per-request PC tag FIFO of depth DEPTH, pushed on accept and popped on response.
- Dequeue (instr_valid && instr_ready):
  - rd_ptr += 1 (mod DEPTH); count -= 1.
  - instr_valid = (count != 0). instr_data and instr_pc come directly from storage at rd_ptr; latency 0 from head update.
- Fetch latency: minimum 2 cycles from request accept to instr_valid (memory latency 1 plus queue write).
- Simultaneous push and pop: count unchanged. When full, a pop allows a same-cycle push only through the credit rule, which has already reserved the slot.
- Redirect (redirect_valid=1) has priority over everything else in the same cycle:
  - Next state: count=0, rd_ptr=wr_ptr=0, fetch_pc=redirect_pc.
  - drop_cnt = outstanding_next, where outstanding_next includes any request accepted this cycle and excludes any response arriving this cycle. That response is discarded.
  - A request accepted in the redirect cycle used the old fetch_pc and is counted for dropping.
  - instr_valid=0 in the cycle after the redirect.
  - Redirects on consecutive cycles: each one re-applies the above; the last one wins.
- Empty: instr_valid=0; instr_data and instr_pc hold stale values (don't-care).
- fetch_en=0: the pipeline drains; fetch_pc holds.

Test Plan:
- Reset sequence: rst=1 then 0, fetch_en=1, memory ready with 1-cycle latency, instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, 0xC… with matching words, one per cycle after fill.
- Backpressure: instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, occupancy=4, imem_req_valid=0. Then instr_ready=1 -> 4 entries drained in order, fetch resumes at 0x10.
- Redirect with in-flight traffic: 3-cycle memory latency, 2 outstanding at 0x8/0xC, pulse redirect_pc=0x100 -> both stale responses dropped, next instr_pc=0x100, then 0x104.
- Redirect same cycle as response and request accept -> response discarded, drop_cnt covers the accepted request, no stale PC is ever presented on instr_pc.
- PC wrap: RESET_PC=0xFFFFFFF8 -> instr_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Async reset mid-run: rst pulsed between clock edges with occupancy=3 -> instr_valid and occupancy go to 0 immediately, without waiting for clk; fetch restarts at RESET_PC.
